mem_access_unit: RTL and testbench

MEM-stage initiator for the multicycle MIPS datapath. It accepts one load/store request from control and drives the word-addressed data memory port: memWrite, memRead, memaddress, invalue and the stage-4 strobe. It captures outvalue, formats load results, and pulses done so control can advance to stage 5. Byte stores use read-modify-write because the memory is word-only.

---
 rtl/mem_access_pkg.sv | 40 ++++
 rtl/byte_lane_merge.sv | 31 +++
 rtl/mem_access_unit.sv | 194 +++++++++++++++++++
 tb/tb_mem_access_unit.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// ============================================================================
// Module   : mem_access_pkg
// Brief    : Shared op codes, MEM-stage state encoding and big-endian lanes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_pkg;

    typedef enum logic [1:0] {
        OP_LW = 2'b00,
        OP_SW = 2'b01,
        OP_LB = 2'b10,
        OP_SB = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        CAPTURE = 3'd2,
        MERGE   = 3'd3,
        WRITE   = 3'd4,
        FIN     = 3'd5
    } state_e;

    // Big-endian: byte offset 0 lives in the most significant lane.
    localparam logic [1:0] LANE_B0 = 2'd0;
    localparam logic [1:0] LANE_B1 = 2'd1;
    localparam logic [1:0] LANE_B2 = 2'd2;
    localparam logic [1:0] LANE_B3 = 2'd3;
    localparam int         LANE_W  = 8;

    // Bit position of the lane's LSB: 8 * (3 - sel).
    function automatic logic [4:0] lane_lsb(input logic [1:0] sel);
        return {~sel, 3'b000};
    endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_merge.sv
// ============================================================================
// Module   : byte_lane_merge
// Brief    : Big-endian byte extract/sign-extend and byte merge into a word.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_lane_merge
    import mem_access_pkg::*;
(
    input  logic [1:0]  i_sel,
    input  logic [31:0] i_word,
    input  logic [7:0]  i_byte,
    output logic [31:0] o_byte_sext,
    output logic [31:0] o_word_merged
);

    logic [4:0]        w_lsb;
    logic [LANE_W-1:0] w_byte;

    always_comb begin
        w_lsb         = lane_lsb(i_sel);
        w_byte        = i_word[w_lsb +: LANE_W];
        o_byte_sext   = {{(32-LANE_W){w_byte[LANE_W-1]}}, w_byte};
        o_word_merged = i_word;
        o_word_merged[w_lsb +: LANE_W] = i_byte;
    end

endmodule

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
// Module   : mem_access_unit
// Brief    : MEM-stage load/store initiator for a word-only data memory;
//            byte stores use read-modify-write. Optional MEM_ACCESS_COUNT_EN
//            adds saturating read/write strobe counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 128
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [31:0]       addr,
    input  logic [31:0]       store_data,
    output logic [31:0]       load_data,
    output logic              done,
    output logic              error,
    output logic              busy,
    output logic              memWrite,
    output logic              memRead,
    output logic [ADDR_W-1:0] memaddress,
    output logic [DATA_W-1:0] invalue,
    output logic              mem_stage4,
    input  logic [DATA_W-1:0] outvalue
`ifdef MEM_ACCESS_COUNT_EN
    ,
    output logic [15:0]       rd_count,
    output logic [15:0]       wr_count
`endif
);

    localparam logic [31:0] C_WORD_LIMIT = 32'(MEM_WORDS);

    state_e              state_q, state_d;
    op_e                 op_q, op_d;
    logic [ADDR_W+1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic                err_q, err_d;
    logic [31:0]         load_data_q, load_data_d;
    logic [31:0]         wbuf_q, wbuf_d;

    logic [31:0]         w_word_idx;
    logic                w_req_err;
    logic [31:0]         w_byte_sext;
    logic [31:0]         w_word_merged;

    byte_lane_merge u_lane (
        .i_sel         (addr_q[1:0]),
        .i_word        (outvalue),
        .i_byte        (wdata_q[7:0]),
        .o_byte_sext   (w_byte_sext),
        .o_word_merged (w_word_merged)
    );

    // Request validation uses the live inputs at the accepting edge.
    always_comb begin
        w_word_idx = 32'(addr[ADDR_W+1:2]);
        w_req_err  = (addr[31:ADDR_W+2] != '0)
                  || (w_word_idx >= C_WORD_LIMIT)
                  || (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        err_d       = err_q;
        load_data_d = load_data_q;
        wbuf_d      = wbuf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    op_d    = op_e'(op);
                    addr_d  = addr[ADDR_W+1:0];
                    wdata_d = store_data;
                    err_d   = w_req_err;
                    state_d = w_req_err ? FIN : ISSUE;
                end
            end
            ISSUE: begin
                case (op_q)
                    OP_SW:   state_d = FIN;
                    OP_SB:   state_d = MERGE;
                    default: state_d = CAPTURE;
                endcase
            end
            CAPTURE: begin
                load_data_d = (op_q == OP_LW) ? outvalue : w_byte_sext;
                state_d     = FIN;
            end
            MERGE: begin
                wbuf_d  = w_word_merged;
                state_d = WRITE;
            end
            WRITE:   state_d = FIN;
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            op_q        <= OP_LW;
            addr_q      <= '0;
            wdata_q     <= '0;
            err_q       <= 1'b0;
            load_data_q <= '0;
            wbuf_q      <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            err_q       <= err_d;
            load_data_q <= load_data_d;
            wbuf_q      <= wbuf_d;
        end
    end

    // Memory port is a pure function of state; idle states drive all zeros.
    always_comb begin
        mem_stage4 = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        memaddress = '0;
        invalue    = '0;
        case (state_q)
            ISSUE: begin
                mem_stage4 = 1'b1;
                memaddress = addr_q[ADDR_W+1:2];
                if (op_q == OP_SW) begin
                    memWrite = 1'b1;
                    invalue  = wdata_q;
                end else begin
                    memRead  = 1'b1;
                end
            end
            WRITE: begin
                mem_stage4 = 1'b1;
                memWrite   = 1'b1;
                memaddress = addr_q[ADDR_W+1:2];
                invalue    = wbuf_q;
            end
            default: ;
        endcase
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == FIN);
    assign error     = (state_q == FIN) && err_q;
    assign load_data = load_data_q;

`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;

    always_comb begin
        rd_count_d = rd_count_q;
        wr_count_d = wr_count_q;
        if (mem_stage4 && memRead && (rd_count_q != 16'hFFFF)) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if (mem_stage4 && memWrite && (wr_count_q != 16'hFFFF)) begin
            wr_count_d = wr_count_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_count_q <= '0;
            wr_count_q <= '0;
        end else begin
            rd_count_q <= rd_count_d;
            wr_count_q <= wr_count_d;
        end
    end

    assign rd_count = rd_count_q;
    assign wr_count = wr_count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
// Module   : tb_mem_access_unit
// Brief    : Directed self-checking bench for mem_access_unit with a
//            word-addressed memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_unit;

    localparam logic [1:0] C_LW = 2'b00;
    localparam logic [1:0] C_SW = 2'b01;
    localparam logic [1:0] C_LB = 2'b10;
    localparam logic [1:0] C_SB = 2'b11;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] addr = '0;
    logic [31:0] store_data = '0;
    logic [31:0] load_data;
    logic        done, error, busy, memWrite, memRead, mem_stage4;
    logic [7:0]  memaddress;
    logic [31:0] invalue;
    logic [31:0] outvalue;
`ifdef MEM_ACCESS_COUNT_EN
    logic [15:0] rd_count, wr_count;
`endif

    mem_access_unit dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .op         (op),
        .addr       (addr),
        .store_data (store_data),
        .load_data  (load_data),
        .done       (done),
        .error      (error),
        .busy       (busy),
        .memWrite   (memWrite),
        .memRead    (memRead),
        .memaddress (memaddress),
        .invalue    (invalue),
        .mem_stage4 (mem_stage4),
        .outvalue   (outvalue)
`ifdef MEM_ACCESS_COUNT_EN
        ,
        .rd_count   (rd_count),
        .wr_count   (wr_count)
`endif
    );

    always #5 clock = ~clock;

    logic [31:0] mem [0:255];
    int cyc = 0, rd_cnt = 0, wr_cnt = 0, both_cnt = 0, done_cnt = 0;
    int last_rd_cyc = 0, last_wr_cyc = 0, e0_cyc = 0;
    logic [31:0] last_wr_val = '0;

    // Memory model plus strobe monitor; sees pre-edge values at each posedge.
    always @(posedge clock) begin
        if (mem_stage4 && memWrite) begin
            mem[memaddress] <= invalue;
            wr_cnt          <= wr_cnt + 1;
            last_wr_cyc     <= cyc;
            last_wr_val     <= invalue;
        end
        if (mem_stage4 && memRead) begin
            outvalue    <= mem[memaddress];
            rd_cnt      <= rd_cnt + 1;
            last_rd_cyc <= cyc;
        end
        if (memRead && memWrite) both_cnt <= both_cnt + 1;
        if (done)                done_cnt <= done_cnt + 1;
        if (start && !busy && !reset) e0_cyc <= cyc;
        cyc <= cyc + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Issue one request; lat = cycles from the accepting edge to the done cycle.
    task automatic do_req(input logic [1:0] t_op, input logic [31:0] t_addr,
                          input logic [31:0] t_data, output int lat,
                          output logic [31:0] ld, output logic er);
        @(negedge clock);
        start = 1'b1; op = t_op; addr = t_addr; store_data = t_data;
        @(posedge clock);
        #1;
        start = 1'b0; op = ~t_op; addr = 32'hFFFF_FFFF; store_data = 32'h5A5A_5A5A;
        lat = 0;
        ld  = '0;
        er  = 1'b0;
        while (lat < 10) begin
            @(negedge clock);
            lat++;
            if (done) break;
        end
        check("done_seen", 32'(done), 32'd1);
        ld = load_data;
        er = error;
        @(negedge clock);
    endtask

    int          lat, r0, w0, d0;
    logic [31:0] ld;
    logic        er;

    initial begin
        #1;
        check("rst_busy",   32'(busy), 32'd0);
        check("rst_done",   32'(done), 32'd0);
        check("rst_strobe", {29'd0, mem_stage4, memRead, memWrite}, 32'd0);
        check("rst_addr",   32'(memaddress), 32'd0);
        check("rst_load",   load_data, 32'd0);
        check("rst_inval",  invalue, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;

        // Preload through sw, which also exercises the word-store path.
        do_req(C_SW, 32'h10, 32'h1122_3344, lat, ld, er);
        check("sw_lat", 32'(lat), 32'd2);
        check("sw_err", 32'(er), 32'd0);
        check("sw_mem4", mem[4], 32'h1122_3344);
        do_req(C_SW, 32'h14, 32'h8899_AABB, lat, ld, er);
        check("sw_mem5", mem[5], 32'h8899_AABB);

        r0 = rd_cnt; w0 = wr_cnt; d0 = done_cnt;
        do_req(C_LW, 32'h10, 32'h0, lat, ld, er);
        check("lw_lat",  32'(lat), 32'd3);
        check("lw_data", ld, 32'h1122_3344);
        check("lw_err",  32'(er), 32'd0);
        check("lw_rd",   32'(rd_cnt - r0), 32'd1);
        check("lw_wr",   32'(wr_cnt - w0), 32'd0);
        check("lw_done", 32'(done_cnt - d0), 32'd1);

        do_req(C_LB, 32'h14, 32'h0, lat, ld, er);
        check("lb14_lat",  32'(lat), 32'd3);
        check("lb14_data", ld, 32'hFFFF_FF88);
        do_req(C_LB, 32'h13, 32'h0, lat, ld, er);
        check("lb13_data", ld, 32'h0000_0044);
        do_req(C_LB, 32'h17, 32'h0, lat, ld, er);
        check("lb17_data", ld, 32'hFFFF_FFBB);
        check("lb17_err",  32'(er), 32'd0);

        r0 = rd_cnt; w0 = wr_cnt;
        do_req(C_SB, 32'h11, 32'h0000_00EE, lat, ld, er);
        check("sb_lat",    32'(lat), 32'd4);
        check("sb_mem4",   mem[4], 32'h11EE_3344);
        check("sb_rd",     32'(rd_cnt - r0), 32'd1);
        check("sb_wr",     32'(wr_cnt - w0), 32'd1);
        check("sb_rd_e",   32'(last_rd_cyc - e0_cyc), 32'd1);
        check("sb_wr_e",   32'(last_wr_cyc - e0_cyc), 32'd3);
        check("sb_wr_val", last_wr_val, 32'h11EE_3344);
        check("sb_load",   load_data, 32'hFFFF_FFBB);

        // Misaligned word store and out-of-range accesses.
        r0 = rd_cnt; w0 = wr_cnt;
        do_req(C_SW, 32'h13, 32'hDEAD_BEEF, lat, ld, er);
        check("sw_mis_lat", 32'(lat), 32'd1);
        check("sw_mis_err", 32'(er), 32'd1);
        check("sw_mis_ld",  ld, 32'hFFFF_FFBB);
        do_req(C_LW, 32'h400, 32'h0, lat, ld, er);
        check("lw_rng_lat", 32'(lat), 32'd1);
        check("lw_rng_err", 32'(er), 32'd1);
        do_req(C_LB, 32'h200, 32'h0, lat, ld, er);
        check("lb_idx128_err", 32'(er), 32'd1);
        check("err_strobes", 32'((rd_cnt - r0) + (wr_cnt - w0)), 32'd0);
        do_req(C_LB, 32'h1FF, 32'h0, lat, ld, er);
        check("lb_idx127_lat", 32'(lat), 32'd3);
        check("lb_idx127_err", 32'(er), 32'd0);

        // Restore word 4 and round-trip a new word.
        do_req(C_SW, 32'h10, 32'h1122_3344, lat, ld, er);
        do_req(C_SW, 32'h18, 32'hCAFE_BABE, lat, ld, er);
        do_req(C_LW, 32'h18, 32'h0, lat, ld, er);
        check("lw18_data", ld, 32'hCAFE_BABE);

        // Reset while the byte store sits in MERGE.
        w0 = wr_cnt;
        @(negedge clock);
        start = 1'b1; op = C_SB; addr = 32'h11; store_data = 32'h0000_00EE;
        @(posedge clock);
        #1 start = 1'b0;
        repeat (2) @(negedge clock);
        check("merge_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("rmid_busy",   32'(busy), 32'd0);
        check("rmid_strobe", {29'd0, mem_stage4, memRead, memWrite}, 32'd0);
        check("rmid_load",   load_data, 32'd0);
        check("rmid_done",   32'(done), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        check("rmid_mem4", mem[4], 32'h1122_3344);
        check("rmid_wr",   32'(wr_cnt - w0), 32'd0);

        // start held through ISSUE and CAPTURE must not spawn a second request.
        r0 = rd_cnt; d0 = done_cnt;
        @(negedge clock);
        start = 1'b1; op = C_LW; addr = 32'h10;
        repeat (3) @(negedge clock);
        start = 1'b0;
        check("rs_done_now", 32'(done), 32'd1);
        repeat (3) @(negedge clock);
        check("rs_done_cnt", 32'(done_cnt - d0), 32'd1);
        check("rs_rd_cnt",   32'(rd_cnt - r0), 32'd1);
        check("rs_data",     load_data, 32'h1122_3344);
`ifdef MEM_ACCESS_COUNT_EN
        check("rs_rd_count", 32'(rd_count), 32'd1);
        check("rs_wr_count", 32'(wr_count), 32'd0);
`endif
        check("rw_overlap", 32'(both_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
